lsu: RTL and testbench

Load/store unit sitting between the pipeline's memory stage and the single-port data memory. It accepts one load or store per cycle over a valid/ready handshake. Stores go into a small in-order store buffer that drains to memory whenever the port is free. Loads are read through the port and return data one cycle later.

---
 rtl/lsu_pkg.sv | 11 +
 rtl/lsu_if.sv | 26 ++
 rtl/lsu_store_buf.sv | 68 ++++++
 rtl/lsu.sv | 74 +++++++
 tb/tb_lsu.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, store-buffer entry type and default buffer depth for the load/store unit.
package lsu_pkg;
    localparam int ADDR_LINE    = 8;
    localparam int D_SIZE       = 16;
    localparam int LSU_SB_DEPTH = 2;

    typedef struct packed {
        logic [ADDR_LINE-1:0] addr;
        logic [D_SIZE-1:0]    data;
    } sb_entry_t;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response and data-memory port bundle of the load/store unit.
interface lsu_if;
    import lsu_pkg::*;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_rw;
    logic [ADDR_LINE-1:0] req_addr;
    logic [D_SIZE-1:0]    req_wdata;
    logic                 rsp_valid;
    logic [D_SIZE-1:0]    rsp_rdata;
    logic                 mem_update;
    logic                 mem_rw;
    logic [ADDR_LINE-1:0] mem_addr;
    logic [D_SIZE-1:0]    mem_wdata;
    logic [D_SIZE-1:0]    mem_rdata;
    logic                 sb_empty;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_update, mem_rw, mem_addr, mem_wdata, sb_empty
    );
    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_update, mem_rw, mem_addr, mem_wdata, sb_empty
    );
endinterface

// File: rtl/lsu_store_buf.sv
// lsu_store_buf: in-order circular store buffer; LSU_STORE_FWD_EN adds a youngest-match lookup port.
module lsu_store_buf
    import lsu_pkg::*;
#(
    parameter int DEPTH = LSU_SB_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  sb_entry_t            push_entry,
    output sb_entry_t            head,
    output logic                 full,
    output logic                 empty
`ifdef LSU_STORE_FWD_EN
    ,
    input  logic [ADDR_LINE-1:0] lookup_addr,
    output logic                 hit,
    output logic [D_SIZE-1:0]    hit_data
`endif
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t     ent_q [DEPTH];
    sb_entry_t     ent_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        ent_d = ent_q;
        if (push) ent_d[tail_q] = push_entry;
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    assign head  = ent_q[head_q];
    assign full  = count_q == (PW+1)'(DEPTH);
    assign empty = count_q == '0;

`ifdef LSU_STORE_FWD_EN
    // Walk oldest to youngest so the last hit seen is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < count_q && ent_q[head_q + PW'(i)].addr == lookup_addr) begin
                hit      = 1'b1;
                hit_data = ent_q[head_q + PW'(i)].data;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit arbitrating one shared memory port between loads and store-buffer drains.
// LSU_STORE_FWD_EN: loads forward from buffered stores instead of waiting for the buffer to drain.
module lsu
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = LSU_SB_DEPTH
) (
    input logic  clk,
    input logic  reset,
    lsu_if.slave bus
);
    logic              full, empty, ld, st, drain;
    logic [D_SIZE-1:0] load_data;
    sb_entry_t         head, push_entry;
    logic              rsp_valid_q, rsp_valid_d;
    logic [D_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_STORE_FWD_EN
    logic              hit;
    logic [D_SIZE-1:0] hit_data;
`endif

    lsu_store_buf #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .push       (st),
        .pop        (drain),
        .push_entry (push_entry),
        .head       (head),
        .full       (full),
        .empty      (empty)
`ifdef LSU_STORE_FWD_EN
        ,
        .lookup_addr(bus.req_addr),
        .hit        (hit),
        .hit_data   (hit_data)
`endif
    );

`ifdef LSU_STORE_FWD_EN
    assign bus.req_ready = !full;
    assign load_data     = hit ? hit_data : bus.mem_rdata;
`else
    assign bus.req_ready = !full && !(bus.req_valid && !bus.req_rw && !empty);
    assign load_data     = bus.mem_rdata;
`endif

    // Requests seen while reset is high are ignored so the port stays idle.
    always_comb begin
        push_entry     = '{addr: bus.req_addr, data: bus.req_wdata};
        ld             = bus.req_valid && bus.req_ready && !bus.req_rw && !reset;
        st             = bus.req_valid && bus.req_ready && bus.req_rw && !reset;
        drain          = !ld && !empty;
        bus.mem_update = drain;
        bus.mem_rw     = drain;
        bus.mem_addr   = ld ? bus.req_addr : drain ? head.addr : '0;
        bus.mem_wdata  = drain ? head.data : '0;
        bus.sb_empty   = empty;
        rsp_valid_d    = ld;
        rsp_rdata_d    = ld ? load_data : rsp_rdata_q;
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed plus random load/store traffic checked against a queue-and-array model of the lsu.
module tb_lsu;
    import lsu_pkg::*;
`ifdef LSU_STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int DEPTH = LSU_SB_DEPTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    lsu_if bus ();
    lsu #(.SB_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [D_SIZE-1:0] tbmem [256] = '{default: '0};
    assign bus.mem_rdata = tbmem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_update && bus.mem_rw) tbmem[bus.mem_addr] <= bus.mem_wdata;

    sb_entry_t         q [$];
    logic [D_SIZE-1:0] mm [256] = '{default: '0};
    logic [D_SIZE-1:0] last_rsp = '0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input logic v, input logic rw, input logic [ADDR_LINE-1:0] a,
                        input logic [D_SIZE-1:0] d, output logic acc);
        logic rdy, ld, st, dr;
        logic [D_SIZE-1:0] ld_data;
        int n;
        n = q.size();
        bus.req_valid = v;
        bus.req_rw    = rw;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #2;
        rdy = (n < DEPTH) && (FWD || !(v && !rw && n != 0));
        ld  = v && rdy && !rw;
        st  = v && rdy && rw;
        dr  = !ld && n != 0;
        chk("req_ready", bus.req_ready, rdy);
        chk("sb_empty", bus.sb_empty, n == 0);
        chk("mem_update", bus.mem_update, dr);
        chk("mem_rw", bus.mem_rw, dr);
        chk("mem_addr", bus.mem_addr, ld ? a : dr ? q[0].addr : '0);
        chk("mem_wdata", bus.mem_wdata, dr ? q[0].data : '0);
        ld_data = mm[a];
        if (FWD) foreach (q[i]) if (q[i].addr == a) ld_data = q[i].data;
        @(posedge clk);
        if (dr) begin
            mm[q[0].addr] = q[0].data;
            void'(q.pop_front());
        end
        if (st) q.push_back('{addr: a, data: d});
        #1;
        chk("rsp_valid", bus.rsp_valid, ld);
        if (ld) last_rsp = ld_data;
        chk("rsp_rdata", bus.rsp_rdata, last_rsp);
        bus.req_valid = 1'b0;
        acc = v && rdy;
    endtask

    task automatic req(input logic rw, input logic [ADDR_LINE-1:0] a, input logic [D_SIZE-1:0] d);
        logic acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, rw, a, d, acc);
        chk("accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, acc);
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 8'd7;
        bus.req_wdata = '0;
        reset = 1'b1;
        #2;
        chk("rst_sb_empty", bus.sb_empty, 1'b1);
        chk("rst_mem_update", bus.mem_update, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, '0);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, '0);
        @(posedge clk);
        #1;
        chk("rst_rsp_valid_edge", bus.rsp_valid, 1'b0);
        chk("rst_mem_update_edge", bus.mem_update, 1'b0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        last_rsp = '0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        @(posedge clk);
        #1;
        do_reset();
        req(1'b1, 8'd3, 16'h00A5);
        idle(2);
        req(1'b0, 8'd3, '0);
        idle(1);
        chk("load_mem_value", bus.rsp_rdata, 16'h00A5);
        req(1'b1, 8'd5, 16'h0011);
        req(1'b1, 8'd5, 16'h0022);
        req(1'b0, 8'd5, '0);
        idle(1);
        chk("same_addr_youngest", bus.rsp_rdata, 16'h0022);
        idle(2);
        req(1'b1, 8'd8, 16'h0001);
        req(1'b1, 8'd9, 16'h0002);
        for (int k = 0; k < 4; k++) req(1'b0, 8'd8, '0);
        idle(3);
        req(1'b1, 8'd6, 16'h0066);
        req(1'b1, 8'd7, 16'h0077);
        idle(2);
        req(1'b1, 8'd12, 16'hBEEF);
        do_reset();
        req(1'b0, 8'd12, '0);
        idle(1);
        chk("reset_drops_store", bus.rsp_rdata, 16'h0000);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
        end
        idle(4);
        for (int i = 0; i < 16; i++) chk("mem_contents", tbmem[i], mm[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
